// File: rtl/decode_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decode_block_sequencer
// Purpose  : Per-block scheduler of the JPEG decode path: RLE word fetch,
//            IDCT kick-off, and copy of 8 IDCT rows into the output SRAM.
// Revision : 1.0  initial release
// ============================================================================
module decode_block_sequencer #(
   parameter int NUM_BLOCKS = 4096,
   parameter int IN_AW      = 14,
   parameter int OUT_AW     = 15,
   parameter int IN_DEPTH   = 16384
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              in_rd_en,
   output logic [IN_AW-1:0]  in_addr,
   output logic              rle_valid,
   input  logic              rle_ready,
   input  logic              rle_eob,
   output logic              idct_start,
   input  logic              idct_done,
   output logic              idct_row_rd,
   output logic [2:0]        idct_row_idx,
   output logic              out_wr_en,
   output logic [OUT_AW-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                c_blk_w    = OUT_AW - 3;
   localparam logic [IN_AW:0]    c_in_last  = (IN_AW+1)'(IN_DEPTH);
   localparam logic [c_blk_w-1:0] c_last_blk = c_blk_w'(NUM_BLOCKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_KICK      = 3'd2,
      ST_WAIT_IDCT = 3'd3,
      ST_COPY      = 3'd4,
      ST_DRAIN     = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   state_t              r_state;
   logic [IN_AW:0]      r_cnt;
   logic [c_blk_w-1:0]  r_block;
   logic                r_valid;
   logic                r_idct_start;
   logic                r_row_rd;
   logic [2:0]          r_row;
   logic                r_wr_en;
   logic [OUT_AW-1:0]   r_out_addr;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic                w_rd_en;

   // A read is issued only while no word is in flight, so EOB never over-fetches.
   assign w_rd_en = (r_state == ST_FETCH) && rle_ready && !r_valid && (r_cnt != c_in_last);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_block      <= '0;
         r_valid      <= 1'b0;
         r_idct_start <= 1'b0;
         r_row_rd     <= 1'b0;
         r_row        <= 3'd0;
         r_wr_en      <= 1'b0;
         r_out_addr   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_valid      <= w_rd_en;
         r_idct_start <= 1'b0;
         r_wr_en      <= r_row_rd;
         if (r_row_rd) begin
            r_out_addr <= {r_block, r_row};
         end
         if (w_rd_en) begin
            r_cnt <= r_cnt + (IN_AW+1)'(1);
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state <= ST_FETCH;
                  r_cnt   <= '0;
                  r_block <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (r_valid && rle_eob) begin
                  r_state      <= ST_KICK;
                  r_idct_start <= 1'b1;
               end else if (r_valid && (r_cnt == c_in_last)) begin
                  r_state <= ST_DONE;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_KICK: begin
               r_state <= ST_WAIT_IDCT;
            end
            ST_WAIT_IDCT: begin
               if (idct_done) begin
                  r_state  <= ST_COPY;
                  r_row_rd <= 1'b1;
                  r_row    <= 3'd0;
               end
            end
            ST_COPY: begin
               if (r_row == 3'd7) begin
                  r_state  <= ST_DRAIN;
                  r_row_rd <= 1'b0;
                  r_row    <= 3'd0;
               end else begin
                  r_row <= r_row + 3'd1;
               end
            end
            ST_DRAIN: begin
               if (r_block == c_last_blk) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_block <= r_block + c_blk_w'(1);
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_rd_en     = w_rd_en;
   assign in_addr      = r_cnt[IN_AW-1:0];
   assign rle_valid    = r_valid;
   assign idct_start   = r_idct_start;
   assign idct_row_rd  = r_row_rd;
   assign idct_row_idx = r_row;
   assign out_wr_en    = r_wr_en;
   assign out_addr     = r_out_addr;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;

endmodule
`default_nettype wire
